// File: rtl/corefifo_wr_gray_ptr.sv
// Write-side pointer engine for the async FIFO. It keeps the binary and gray write pointers,
// synchronises the read-domain gray pointer, and derives full, almost-full, occupancy and overflow.
module corefifo_wr_gray_ptr #(
    parameter int ADDRWIDTH    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we,
    input  logic [ADDRWIDTH:0]   rd_ptr_gray,
    output logic [ADDRWIDTH:0]   wr_ptr_gray,
    output logic [ADDRWIDTH-1:0] waddr,
    output logic                 wr_en_mem,
    output logic                 full,
    output logic                 afull,
    output logic [ADDRWIDTH:0]   wr_count,
    output logic                 overflow
);

    localparam int A  = ADDRWIDTH;
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] AFULL_TH = PW'(AFULL_THRESH);

    logic [PW-1:0] rq1_q, rq2_q;
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] rbin;
    logic [PW-1:0] count_d;
    logic [PW-1:0] wr_count_q;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          overflow_q;
    logic          acc;

    // Writes are also suppressed while reset is held, so the RAM sees no stray strobe.
    assign acc = we & ~full_q & rstn;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(rq2_q >> i);
        end
    end

    always_comb begin
        wbin_d  = wbin_q + {{A{1'b0}}, acc};
        wgray_d = wbin_d ^ (wbin_d >> 1);
        count_d = wbin_d - rbin;
        // Full when the next gray pointer equals the read pointer with its two MSBs inverted.
        full_d  = (wgray_d == {~rq2_q[A:A-1], rq2_q[A-2:0]});
        afull_d = (count_d >= AFULL_TH);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rq1_q      <= '0;
            rq2_q      <= '0;
            wbin_q     <= '0;
            wgray_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            wr_count_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            rq1_q      <= rd_ptr_gray;
            rq2_q      <= rq1_q;
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            wr_count_q <= count_d;
            overflow_q <= we & full_q;
        end
    end

    assign wr_ptr_gray = wgray_q;
    assign waddr       = wbin_q[A-1:0];
    assign wr_en_mem   = acc;
    assign full        = full_q;
    assign afull       = afull_q;
    assign wr_count    = wr_count_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/corefifo_wr_gray_ptr.md
Name: corefifo_wr_gray_ptr

Overview:
Write-side pointer engine for the async COREFIFO. It holds the binary write pointer and encodes it binary-to-gray into a registered gray pointer, which the read clock domain synchronizes and decodes back to binary. It also synchronizes the read domain's gray pointer into the write clock, decodes it to binary, and derives full, almost-full, occupancy and overflow. It sits between the write port of the FIFO top and the dual-port RAM write address.

Parameters:
ADDRWIDTH, 3, RAM address width; pointers are ADDRWIDTH+1 bits; depth = 2^ADDRWIDTH; legal range >= 2
AFULL_THRESH, 6, occupancy at or above which afull asserts; legal range 1..2^ADDRWIDTH

Ports:
clk  in  1  write-domain clock
rstn  in  1  synchronous active-low reset, sampled on rising clk
we  in  1  write request from the FIFO user
rd_ptr_gray  in  ADDRWIDTH+1  read pointer, gray coded, from the read clock domain (asynchronous to clk)
wr_ptr_gray  out  ADDRWIDTH+1  registered gray write pointer, sent to the read domain
waddr  out  ADDRWIDTH  RAM write address = wbin[ADDRWIDTH-1:0]
wr_en_mem  out  1  RAM write strobe = we & ~full (combinational)
full  out  1  registered full flag
afull  out  1  registered almost-full flag
wr_count  out  ADDRWIDTH+1  registered occupancy as seen by the write side
overflow  out  1  one-cycle pulse per rejected write

Behaviour:
- Reset: when rstn=0 at a clk edge, the following clear to 0: wbin, wr_ptr_gray, both synchronizer stages (rq1, rq2), full, afull, wr_count, overflow. A reset applied mid-operation takes effect at that edge; the pre-reset state leaves no residue.
- Synchronizer: rq1 <= rd_ptr_gray, then rq2 <= rq1, one stage per clock. Nothing else reads rq1.
- Gray decode: rbin[ADDRWIDTH] = rq2[ADDRWIDTH]; rbin[i-1] = rbin[i] ^ rq2[i-1], computed combinationally.
- Accept: acc = we & ~full.
  - wbin_next = wbin + acc, modulo 2^(ADDRWIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - On each clk edge: wbin <= wbin_next and wr_ptr_gray <= wgray_next.
  - wr_ptr_gray changes at most one bit per cycle.
- Full: full <= (wgray_next == {~rq2[A:A-1], rq2[A-2:0]}), where A = ADDRWIDTH.
  - full asserts on the same edge that accepts the write filling the last slot.
- Occupancy: wr_count <= (wbin_next - rbin) modulo 2^(A+1). Range is 0..2^A.
- Almost full: afull <= ((wbin_next - rbin) mod 2^(A+1)) >= AFULL_THRESH.
- Overflow: overflow <= we & full. A rejected write leaves wbin, wr_ptr_gray and the RAM unchanged.
- Read-side latency: a change on rd_ptr_gray sampled at edge k appears in rq2 at edge k+1. full, afull and wr_count reflect it at edge k+2. Flags are pessimistic: full may stay high up to 3 cycles after a read frees space. full is never low while the FIFO is actually full.
- Wrap-around: wbin rolls over from 2^(A+1)-1 to 0 with no special case. The MSB distinguishes full from empty.
- Simultaneous write and read-pointer change: both are applied in the same cycle's computation, so the count is net.
- we=1 while full and the read pointer frees space in the same cycle: the write is still rejected, because acc uses the registered full. The next cycle's write is accepted.

Test Plan:
- Reset: drive rstn=0 for 2 cycles with we=1 -> every output is 0, wr_en_mem=0, wr_ptr_gray=0000.
- Fill (ADDRWIDTH=3, rd_ptr_gray=0000): 8 consecutive writes -> wr_ptr_gray sequence 0001,0011,0010,0110,0111,0101,0100,1100; waddr runs 0..7; afull rises on the 6th accept edge; full rises on the 8th accept edge; wr_count=8.
- Overflow: a 9th and 10th write while full -> overflow=1 for 2 cycles, wr_en_mem=0, wr_ptr_gray holds 1100.
- Read release: drive rd_ptr_gray=0001 at edge k -> full=0 and wr_count=7 at edge k+2; afull stays 1.
- Wrap: stream 20 writes while rd_ptr_gray tracks wr_ptr_gray (pointer equal) -> after the 16th write wr_ptr_gray=0000; full and afull never assert; wr_count=0; after the 20th write wr_ptr_gray=0110.
- Mid-op reset: after 5 writes, pulse rstn=0 for 1 cycle -> at the next edge wbin=0, wr_ptr_gray=0000, afull=0, wr_count=0; a subsequent write produces wr_ptr_gray=0001.
